// File: rtl/pong_score_pkg.sv
// Shared constants and helpers for the Pong score counter bank.
// Holds the default win thresholds, BCD digit width and BCD-to-binary decode.
package pong_score_pkg;

    localparam int WIN_SHORT_DEFAULT = 11;
    localparam int WIN_LONG_DEFAULT  = 15;
    localparam int BCD_W             = 4;
    localparam int MAX_DIGITS        = 3;
    localparam int BIN_W             = 10;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    // Upper digits are zero-padded by the caller when DIGITS < MAX_DIGITS.
    function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [MAX_DIGITS*BCD_W-1:0] bcd);
        logic [BIN_W-1:0] r;
        r = BIN_W'(bcd[11:8]);
        r = r * BIN_W'(10) + BIN_W'(bcd[7:4]);
        r = r * BIN_W'(10) + BIN_W'(bcd[3:0]);
        return r;
    endfunction

endpackage

// File: rtl/score_counter_bank_if.sv
// Point-request inputs and score/winner outputs of the score counter bank.
// master drives requests and control; slave is the counter bank.
interface score_counter_bank_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2
);
    logic                            srst;
    logic                            _attract;
    logic                            win_sel;
    logic [NUM_PLAYERS-1:0]          point;
    logic [NUM_PLAYERS*DIGITS*4-1:0] score;
    logic [NUM_PLAYERS-1:0]          score_pulse;
    logic [NUM_PLAYERS-1:0]          winner;
    logic                            stop_g;

    modport master (
        output srst, _attract, win_sel, point,
        input  score, score_pulse, winner, stop_g
    );

    modport slave (
        input  srst, _attract, win_sel, point,
        output score, score_pulse, winner, stop_g
    );
endinterface

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter with clear; count updates 1 clk after inc.
// No backpressure: an inc at the all-nines value is dropped and raises no changed strobe.
module bcd_counter
    import pong_score_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    _rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [DIGITS*BCD_W-1:0] count,
    output logic                    changed
);

    logic [DIGITS*BCD_W-1:0] count_nxt;
    logic                    sat;
    logic                    carry;

    // Ripple the +1 upward: each 9 wraps to 0 and passes the carry on.
    always_comb begin
        count_nxt = count;
        sat       = 1'b1;
        carry     = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (count[d*BCD_W +: BCD_W] != 4'd9) sat = 1'b0;
            if (carry) begin
                if (count[d*BCD_W +: BCD_W] == 4'd9) begin
                    count_nxt[d*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    count_nxt[d*BCD_W +: BCD_W] = count[d*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            count   <= '0;
            changed <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            changed <= 1'b0;
        end else if (inc && !sat) begin
            count   <= count_nxt;
            changed <= 1'b1;
        end else begin
            changed <= 1'b0;
        end
    end

endmodule

// File: rtl/score_counter_bank.sv
// Per-player BCD score counters with point edge detect, win threshold and game stop; 1 clk point->score.
// No backpressure: rises during attract, srst or stop are consumed and lost.
module score_counter_bank
    import pong_score_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int DIGITS      = 2,
    parameter int WIN_SHORT   = WIN_SHORT_DEFAULT,
    parameter int WIN_LONG    = WIN_LONG_DEFAULT
) (
    input  logic                 clk,
    input  logic                 _rst,
    score_counter_bank_if.slave  bus
);

    localparam int SCORE_W   = DIGITS * BCD_W;
    localparam int MAX_SCORE = pow10(DIGITS) - 1;

    if (NUM_PLAYERS < 1 || NUM_PLAYERS > 4) begin : g_bad_players
        $error("score_counter_bank: NUM_PLAYERS %0d outside 1..4", NUM_PLAYERS);
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("score_counter_bank: DIGITS %0d outside 1..%0d", DIGITS, MAX_DIGITS);
    end
    if (WIN_SHORT < 1 || WIN_SHORT > MAX_SCORE) begin : g_bad_win_short
        $error("score_counter_bank: WIN_SHORT %0d outside 1..%0d", WIN_SHORT, MAX_SCORE);
    end
    if (WIN_LONG < 1 || WIN_LONG > MAX_SCORE) begin : g_bad_win_long
        $error("score_counter_bank: WIN_LONG %0d outside 1..%0d", WIN_LONG, MAX_SCORE);
    end

    logic [NUM_PLAYERS-1:0] point_q;
    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] inc;
    logic [BIN_W-1:0]       thr;
    logic                   stop;
    logic [SCORE_W-1:0]     score_arr   [NUM_PLAYERS];
    logic                   changed_arr [NUM_PLAYERS];
    logic                   win_arr     [NUM_PLAYERS];

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            point_q <= '0;
        end else begin
            point_q <= bus.point;
        end
    end

    // stop comes from the registered scores, so this path has no loop.
    assign rise = bus.point & ~point_q;
    assign inc  = rise & {NUM_PLAYERS{bus._attract & ~stop & ~bus.srst}};
    assign thr  = bus.win_sel ? BIN_W'(WIN_LONG) : BIN_W'(WIN_SHORT);

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        logic [MAX_DIGITS*BCD_W-1:0] padded;

        bcd_counter #(
            .DIGITS (DIGITS)
        ) u_cnt (
            .clk     (clk),
            ._rst    (_rst),
            .clr     (bus.srst),
            .inc     (inc[i]),
            .count   (score_arr[i]),
            .changed (changed_arr[i])
        );

        always_comb begin
            padded              = '0;
            padded[SCORE_W-1:0] = score_arr[i];
        end

        assign win_arr[i] = (bcd_to_bin(padded) >= thr);
    end

    always_comb begin
        bus.score       = '0;
        bus.score_pulse = '0;
        bus.winner      = '0;
        stop            = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            bus.score[i*SCORE_W +: SCORE_W] = score_arr[i];
            bus.score_pulse[i]              = changed_arr[i];
            bus.winner[i]                   = win_arr[i];
            stop                            = stop | win_arr[i];
        end
        bus.stop_g = stop;
    end

endmodule

// File: tb/tb_score_counter_bank.sv
module tb_score_counter_bank;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    score_counter_bank_if #(.NUM_PLAYERS(2), .DIGITS(2)) bus ();
    score_counter_bank_if #(.NUM_PLAYERS(1), .DIGITS(1)) bus1 ();

    score_counter_bank #(
        .NUM_PLAYERS (2),
        .DIGITS      (2),
        .WIN_SHORT   (11),
        .WIN_LONG    (15)
    ) dut (
        .clk  (clk),
        ._rst (rst_n),
        .bus  (bus)
    );

    score_counter_bank #(
        .NUM_PLAYERS (1),
        .DIGITS      (1),
        .WIN_SHORT   (5),
        .WIN_LONG    (9)
    ) dut1 (
        .clk  (clk),
        ._rst (rst_n),
        .bus  (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: integer scores and previous point levels.
    localparam int MAXS = 99;
    int m_score [2];
    bit m_prev  [2];
    bit m_pulse [2];
    bit m_ws;

    function automatic int thr_of(input bit ws);
        return ws ? 15 : 11;
    endfunction

    function automatic logic [15:0] exp_score();
        logic [15:0] r;
        for (int i = 0; i < 2; i++) r[i*8 +: 8] = {4'(m_score[i] / 10), 4'(m_score[i] % 10)};
        return r;
    endfunction

    function automatic logic [1:0] exp_winner();
        logic [1:0] w;
        for (int i = 0; i < 2; i++) w[i] = (m_score[i] >= thr_of(m_ws));
        return w;
    endfunction

    function automatic logic [1:0] exp_pulse();
        logic [1:0] p;
        for (int i = 0; i < 2; i++) p[i] = m_pulse[i];
        return p;
    endfunction

    task automatic step(input logic [1:0] p, input logic att, input logic sr, input logic ws);
        bit stop;
        bus.point    = p;
        bus._attract = att;
        bus.srst     = sr;
        bus.win_sel  = ws;
        m_ws         = ws;
        @(posedge clk);
        stop = 1'b0;
        for (int i = 0; i < 2; i++) if (m_score[i] >= thr_of(ws)) stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (sr) begin
                m_score[i] = 0;
                m_pulse[i] = 1'b0;
            end else if (p[i] && !m_prev[i] && att && !stop && m_score[i] < MAXS) begin
                m_score[i] = m_score[i] + 1;
                m_pulse[i] = 1'b1;
            end else begin
                m_pulse[i] = 1'b0;
            end
            m_prev[i] = p[i];
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.point     = '0;
        bus._attract  = 1'b1;
        bus.srst      = 1'b0;
        bus.win_sel   = 1'b0;
        bus1.point    = '0;
        bus1._attract = 1'b1;
        bus1.srst     = 1'b0;
        bus1.win_sel  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_score[i] = 0;
            m_prev[i]  = 1'b0;
            m_pulse[i] = 1'b0;
        end
        m_ws = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.score !== 16'h0000) $display("FAIL reset_score: got %h want 0000", bus.score);
        else n_pass++;
        n_checks++;
        if ({bus.winner, bus.stop_g, bus.score_pulse} !== 5'b0)
            $display("FAIL reset_flags: winner %b stop %b pulse %b want all 0", bus.winner, bus.stop_g, bus.score_pulse);
        else n_pass++;
        n_checks++;
        if ({bus1.score, bus1.stop_g} !== 5'b0) $display("FAIL reset_dut1: score %h stop %b want 0", bus1.score, bus1.stop_g);
        else n_pass++;
        rst_n = 1'b1;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.score !== 16'h0000) $display("FAIL idle_score: got %h want 0000", bus.score);
        else n_pass++;
    endtask

    task automatic test_game_to_11();
        int pc;
        pc = 0;
        step(2'b00, 1'b1, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            step(2'b01, 1'b1, 1'b0, 1'b0);
            if (bus.score_pulse[0]) pc++;
            n_checks++;
            if (bus.score !== exp_score()) $display("FAIL game_score: step %0d got %h want %h", k, bus.score, exp_score());
            else n_pass++;
            if (k == 8) begin
                n_checks++;
                if (bus.score[7:0] !== 8'h09) $display("FAIL game_nine: got %h want 09", bus.score[7:0]);
                else n_pass++;
            end
            if (k == 9) begin
                n_checks++;
                if (bus.score[7:0] !== 8'h10) $display("FAIL game_carry: got %h want 10", bus.score[7:0]);
                else n_pass++;
            end
            step(2'b00, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if (pc != 11) $display("FAIL game_pulses: got %0d want 11", pc);
        else n_pass++;
        n_checks++;
        if ({bus.score[7:0], bus.winner, bus.stop_g} !== {8'h11, 2'b01, 1'b1})
            $display("FAIL game_win: score %h winner %b stop %b want 11 01 1", bus.score[7:0], bus.winner, bus.stop_g);
        else n_pass++;
        step(2'b01, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({bus.score[7:0], bus.score_pulse} !== {8'h11, 2'b00})
            $display("FAIL game_stopped: score %h pulse %b want 11 00", bus.score[7:0], bus.score_pulse);
        else n_pass++;
    endtask

    task automatic test_hold_attract();
        int pc;
        pc = 0;
        step(2'b00, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) step(2'b10, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.score !== 16'h0100) $display("FAIL hold_once: got %h want 0100", bus.score);
        else n_pass++;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(2'b10, 1'b0, 1'b0, 1'b0);
            if (bus.score_pulse != 2'b00) pc++;
            step(2'b00, 1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (bus.score !== 16'h0100 || pc != 0) $display("FAIL attract_hold: score %h pulses %0d want 0100 0", bus.score, pc);
        else n_pass++;
    endtask

    task automatic test_simultaneous_srst();
        step(2'b00, 1'b1, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 1'b1, 1'b0, 1'b0);
            step(2'b00, 1'b1, 1'b0, 1'b0);
        end
        n_checks++;
        if ({bus.score, bus.winner} !== {16'h1010, 2'b00}) $display("FAIL sim_ten: score %h winner %b want 1010 00", bus.score, bus.winner);
        else n_pass++;
        step(2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({bus.score, bus.score_pulse, bus.winner} !== {16'h1111, 2'b11, 2'b11})
            $display("FAIL sim_both: score %h pulse %b winner %b want 1111 11 11", bus.score, bus.score_pulse, bus.winner);
        else n_pass++;
        step(2'b00, 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({bus.score, bus.score_pulse} !== {16'h0000, 2'b00}) $display("FAIL srst_rise: score %h pulse %b want 0000 00", bus.score, bus.score_pulse);
        else n_pass++;
        step(2'b11, 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({bus.score, bus.score_pulse} !== {16'h0000, 2'b00}) $display("FAIL srst_held: score %h pulse %b want 0000 00", bus.score, bus.score_pulse);
        else n_pass++;
    endtask

    task automatic test_mode_switch();
        step(2'b00, 1'b1, 1'b1, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(k < 3 ? 2'b11 : 2'b01, 1'b1, 1'b0, 1'b1);
            step(2'b00, 1'b1, 1'b0, 1'b1);
        end
        step(2'b00, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({bus.score, bus.stop_g} !== {16'h0312, 1'b1}) $display("FAIL mode_short: score %h stop %b want 0312 1", bus.score, bus.stop_g);
        else n_pass++;
        step(2'b00, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (bus.stop_g !== 1'b0) $display("FAIL mode_long: stop got %b want 0", bus.stop_g);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step(2'b01, 1'b1, 1'b0, 1'b1);
            step(2'b00, 1'b1, 1'b0, 1'b1);
        end
        n_checks++;
        if ({bus.score[7:0], bus.stop_g} !== {8'h15, 1'b1}) $display("FAIL mode_fifteen: score %h stop %b want 15 1", bus.score[7:0], bus.stop_g);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] p;
        logic       att, sr, ws;
        ws = 1'b0;
        for (int k = 0; k < 400; k++) begin
            p   = 2'($urandom_range(0, 3));
            att = ($urandom_range(0, 9) != 0);
            sr  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) ws = ~ws;
            step(p, att, sr, ws);
            n_checks++;
            if ({bus.score, bus.score_pulse, bus.winner, bus.stop_g} !== {exp_score(), exp_pulse(), exp_winner(), |exp_winner()})
                $display("FAIL random: cyc %0d score %h pulse %b win %b stop %b want %h %b %b %b", k,
                         bus.score, bus.score_pulse, bus.winner, bus.stop_g,
                         exp_score(), exp_pulse(), exp_winner(), |exp_winner());
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int pc;
        pc = 0;
        for (int k = 0; k < 12; k++) begin
            bus1.point = 1'b1;
            @(posedge clk);
            #1;
            if (bus1.score_pulse[0]) pc++;
            bus1.point = 1'b0;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if ({bus1.score, bus1.winner, bus1.stop_g} !== {4'h9, 1'b1, 1'b1})
            $display("FAIL sat_score: score %h winner %b stop %b want 9 1 1", bus1.score, bus1.winner, bus1.stop_g);
        else n_pass++;
        n_checks++;
        if (pc != 9) $display("FAIL sat_pulses: got %0d want 9", pc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_game_to_11();
        test_hold_attract();
        test_simultaneous_srst();
        test_mode_switch();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_counter_bank.md
Name: score_counter_bank

Overview:
Clocked, parametrised successor to the Pong score-counter circuit. It keeps NUM_PLAYERS independent BCD score counters and edge-detects point requests, so one pulse scores one point. It compares each score against a DIP-selectable win threshold and drives the game-stop signal and a one-hot winner vector. It sits between the miss/side-detect logic and the score-digit video generator and sound logic.

Parameters:
NUM_PLAYERS, 2, number of independent score counters (1..4)
DIGITS, 2, BCD digits per score (1..3); maximum score is 10^DIGITS-1
WIN_SHORT, 11, win threshold when win_sel=0
WIN_LONG, 15, win threshold when win_sel=1

Ports:
clk  in  1  system clock
_rst  in  1  asynchronous active-low reset
srst  in  1  synchronous score reset, active high (game start)
_attract  in  1  low = attract mode; scoring inhibited
win_sel  in  1  threshold select (DIP bit 0): 0 = WIN_SHORT, 1 = WIN_LONG
point  in  NUM_PLAYERS  level point request per player; bit i = player i scored
score  out  NUM_PLAYERS*DIGITS*4  packed BCD scores; player i occupies bits [i*DIGITS*4 +: DIGITS*4], least-significant digit lowest
score_pulse  out  NUM_PLAYERS  one-cycle strobe when player i's score increments
winner  out  NUM_PLAYERS  bit i high while score[i] >= active threshold
stop_g  out  1  OR of winner; game stop

Behaviour:
- Reset (_rst low, asynchronous): all score digits 0, point edge-detect registers 0, score_pulse 0. winner and stop_g are therefore 0.
- Edge detect: point_q[i] registers point[i] every cycle. The raw event is rise[i] = point[i] & ~point_q[i].
- Qualified increment: inc[i] = rise[i] & _attract & ~stop_g & ~srst. stop_g here is the registered-score-derived value from the current cycle.
- Increment: score[i] is applied at the next clk edge as BCD +1 with carry across digits. A digit 9 becomes 0 and carries to the next digit.
- Saturation: a score of 10^DIGITS-1 holds. An inc at saturation produces no change and no score_pulse.
- score_pulse[i] is registered and goes high for exactly the cycle after the edge on which score[i] changed.
- srst priority: srst high clears all scores to 0 at the next edge, overriding any simultaneous inc. A rise occurring during srst is consumed and is not replayed later.
- A point held high across srst release does not score; a new rising edge is required.
- Simultaneous events: each player's counter is independent. Several players may increment in the same cycle, and several winner bits may assert together.
- Threshold: thr = win_sel ? WIN_LONG : WIN_SHORT, compared in binary against the BCD-decoded score.
  - winner[i] = (score[i] >= thr), combinational from the score registers. It is therefore valid in the same cycle as score_pulse.
  - stop_g = |winner.
- win_sel is sampled continuously. Changing it mid-game re-evaluates winner immediately. Example: a score of 12 with win_sel changing 0->1 deasserts stop_g, and scoring resumes.
- Scoring is inhibited while stop_g is high; scores hold until srst.
- _attract low: scores hold and are still displayed. Edge detection continues to run, so a rise during attract is lost.
- Elaboration checks: WIN_SHORT and WIN_LONG must each be <= 10^DIGITS-1 and >= 1, otherwise $error. NUM_PLAYERS and DIGITS must be within their ranges.
- Latency: point rise to score/score_pulse update is 1 clk.

Decomposition:
- Shared package pong_score_pkg:
  - constants WIN_SHORT_DEFAULT=11 and WIN_LONG_DEFAULT=15
  - BCD digit width constant of 4
  - function bcd_to_bin for the threshold compare
- Sub-module bcd_counter:
  - one instance per player, generated in a loop
  - DIGITS-parameterised saturating BCD up-counter
  - ports: clk, _rst, clr, inc, count, changed
- score_counter_bank keeps the edge detect, qualification, threshold and stop logic.

Test Plan:
1. Reset/idle: _rst low then high with point=0 -> score=0, winner=0, stop_g=0, score_pulse=0.
2. Game to 11, 2 players, win_sel=0, _attract=1: 11 single-cycle pulses on point[0] -> score[0]=0x11. score_pulse[0] pulses 11 times. winner=2'b01 and stop_g=1 from the cycle after the 11th pulse. A 12th pulse leaves the score at 0x11 with no score_pulse.
3. Hold and attract: point[1] held high for 50 cycles -> exactly +1. With _attract=0, 5 pulses -> score unchanged and score_pulse stays 0.
4. Simultaneous and srst:
   - Both point bits rise in the same cycle with scores at 10/10 -> both reach 11, winner=2'b11.
   - srst asserted in the same cycle as a point rise -> all scores 0 and no pulse.
5. Mode switch: score 12-3 with win_sel=0 (stop_g=1); set win_sel=1 -> stop_g=0. 3 more pulses on point[0] -> 15, stop_g=1.
6. Saturation and carry, DIGITS=1, WIN_LONG=9: 12 pulses -> score sticks at 9. With DIGITS=2, the 9->10 transition produces BCD 0x10.
